// File: rtl/kypd_scan.sv
// kypd_scan: 4x4 active-low keypad scanner with per-scan debounce and a three-digit entry register.
// Define KYPD_HEX_ENTRY_EN to let accepted A, B, D, E, F shift into x alongside 0..9.
module kypd_scan #(
  parameter int SCAN_DIV_W = 14,
  parameter int DEB_SCANS  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [11:0] x
);

  localparam int         CW  = SCAN_DIV_W + 2;
  localparam logic [3:0] DEB = 4'(DEB_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    col_idx;
  logic          sample, scan_end;
  logic [2:0]    cur_cnt, sum;
  logic [3:0]    cur_code;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic          res_none, res_single;
  logic [3:0]    res_code;
  logic [3:0]    cand, cand_n;
  logic [3:0]    cnt, cnt_n;
  logic          accept;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      4'hF: k = 4'hD;
      default: k = 4'h0;
    endcase
    return k;
  endfunction

  assign col_idx  = scan_cnt[CW-1 -: 2];
  assign col      = ~(4'b0001 << col_idx);
  assign sample   = &scan_cnt[SCAN_DIV_W-1:0];
  assign scan_end = sample && (col_idx == 2'd3);

  always_comb begin
    cur_cnt  = '0;
    cur_code = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!row[r]) begin
        cur_cnt  = cur_cnt + 3'd1;
        cur_code = key_map(2'(r), col_idx);
      end
    end
  end

  // acc_cnt saturates at 2: anything beyond one low bit per scan is MULTI.
  assign sum        = {1'b0, acc_cnt} + cur_cnt;
  assign res_none   = (sum == 3'd0);
  assign res_single = (sum == 3'd1);
  assign res_code   = (acc_cnt == 2'd1) ? acc_code : cur_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      acc_cnt  <= '0;
      acc_code <= '0;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
      if (sample) begin
        if (scan_end) begin
          acc_cnt  <= '0;
          acc_code <= '0;
        end else begin
          acc_cnt <= (sum >= 3'd2) ? 2'd2 : sum[1:0];
          if (acc_cnt == 2'd0 && cur_cnt == 3'd1) acc_code <= cur_code;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (scan_end) begin
      unique case (state)
        IDLE: begin
          if (res_single) begin
            cand_n = res_code;
            cnt_n  = 4'd1;
            if (DEB == 4'd1) begin
              state_n = PRESSED;
              accept  = 1'b1;
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (res_single && res_code == cand) begin
            cnt_n = cnt + 4'd1;
            if (cnt + 4'd1 == DEB) begin
              state_n = PRESSED;
              accept  = 1'b1;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PRESSED: begin
          if (res_none) begin
            cnt_n   = 4'd1;
            state_n = (DEB == 4'd1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (res_none) begin
            cnt_n = cnt + 4'd1;
            if (cnt + 4'd1 == DEB) state_n = IDLE;
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      x         <= '0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      cnt       <= cnt_n;
      key_valid <= accept;
      if (accept) begin
        key_code <= cand_n;
        if (cand_n <= 4'd9) x <= {x[7:0], cand_n};
        else if (cand_n == 4'hC) x <= '0;
`ifdef KYPD_HEX_ENTRY_EN
        else x <= {x[7:0], cand_n};
`else
        else x <= x;
`endif
      end
    end
  end

endmodule

// File: tb/tb_kypd_scan.sv
// tb_kypd_scan: directed and randomized bench for kypd_scan; a keypad model drives row from col.
// Expectations come from a per-scan run-length model of the press/release debounce rules.
module tb_kypd_scan;

  localparam int SCAN_DIV_W = 2;
  localparam int DEB_SCANS  = 3;
  localparam int SCAN_CYC   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] x;
  logic [15:0] keys = '0;

  logic [3:0] key_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'h0, 4'hF, 4'hE, 4'hD};

  int checks = 0;
  int fails = 0;
  int total_pulses = 0;

  bit         armed;
  int         run_len, none_len;
  logic [3:0] run_key, exp_code;
  logic [11:0] exp_x;

  kypd_scan #(.SCAN_DIV_W(SCAN_DIV_W), .DEB_SCANS(DEB_SCANS)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_valid(key_valid), .key_code(key_code), .x(x)
  );

  always #5 clk = ~clk;

  // keys[r*4+c] set means the key at row r, column c is held down
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] key_bit(input logic [3:0] code);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) if (key_tbl[i] == code) b = 16'h0001 << i;
    return b;
  endfunction

  task automatic model_reset();
    armed = 1'b1; run_len = 0; none_len = 0;
    run_key = '0; exp_code = '0; exp_x = '0;
  endtask

  task automatic model_scan(input logic [15:0] k, output bit acc);
    int n;
    logic [3:0] code;
    acc = 1'b0;
    n = $countones(k);
    code = '0;
    for (int i = 0; i < 16; i++) if (k[i]) code = key_tbl[i];
    if (n == 0) begin
      run_len = 0;
      none_len++;
      if (!armed && none_len >= DEB_SCANS) armed = 1'b1;
    end else if (n == 1) begin
      none_len = 0;
      // a different single key breaks the run without starting a new one
      if (run_len > 0 && code != run_key) run_len = 0;
      else begin
        run_key = code;
        run_len++;
      end
      if (armed && run_len == DEB_SCANS) begin
        acc = 1'b1;
        armed = 1'b0;
        exp_code = code;
        if (code <= 4'd9) exp_x = {exp_x[7:0], code};
        else if (code == 4'hC) exp_x = '0;
`ifdef KYPD_HEX_ENTRY_EN
        else exp_x = {exp_x[7:0], code};
`endif
      end
    end else begin
      run_len = 0;
      none_len = 0;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int n_scans);
    for (int s = 0; s < n_scans; s++) begin
      bit acc;
      int hit, stray;
      logic [3:0] exp_col;
      keys = k;
      hit = 0;
      stray = 0;
      for (int i = 0; i < SCAN_CYC; i++) begin
        @(posedge clk);
        #1;
        exp_col = ~(4'b0001 << (((i + 1) % SCAN_CYC) / 4));
        checkOutput("col", col, exp_col);
        if (key_valid) begin
          if (i == SCAN_CYC - 1) hit++;
          else stray++;
        end
      end
      model_scan(k, acc);
      total_pulses += hit;
      checkOutput("key_valid_pulse", hit, acc);
      checkOutput("key_valid_stray", stray, 0);
      checkOutput("key_code", key_code, exp_code);
      checkOutput("x", x, exp_x);
    end
  endtask

  task automatic applyReset(input int pre_cycles);
    repeat (pre_cycles) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_col", col, 4'b1110);
    checkOutput("rst_key_valid", key_valid, 1'b0);
    checkOutput("rst_key_code", key_code, 4'h0);
    checkOutput("rst_x", x, 12'h000);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic tap(input logic [3:0] code);
    applyStimulus(key_bit(code), 3);
    applyStimulus(16'h0000, 3);
  endtask

  initial begin
    int base;
    applyReset(0);

    applyStimulus(key_bit(4'h5), 6);
    applyStimulus(16'h0000, 4);
    checkOutput("single_press_pulses", total_pulses, 1);
    checkOutput("single_press_code", key_code, 4'h5);
    checkOutput("single_press_x", x, 12'h005);
    tap(4'h5);
    checkOutput("repress_after_idle", total_pulses, 2);

    base = total_pulses;
    tap(4'h1); tap(4'h2); tap(4'h3);
    checkOutput("x_123", x, 12'h123);
    tap(4'h4);
    checkOutput("x_234", x, 12'h234);
    checkOutput("four_pulses", total_pulses - base, 4);

    tap(4'hC);
    checkOutput("clear_x", x, 12'h000);
    checkOutput("clear_code", key_code, 4'hC);

    base = total_pulses;
    applyStimulus(key_bit(4'h5), 2);
    applyStimulus(16'h0000, 1);
    applyStimulus(key_bit(4'h5), 2);
    applyStimulus(16'h0000, 3);
    checkOutput("bounce_no_pulse", total_pulses - base, 0);
    checkOutput("bounce_x", x, 12'h000);

    base = total_pulses;
    applyStimulus(key_bit(4'h1) | key_bit(4'h2), 6);
    applyStimulus(16'h0000, 3);
    checkOutput("multi_no_pulse", total_pulses - base, 0);

    applyStimulus(key_bit(4'h7), 5);
    applyReset(5);
    base = total_pulses;
    applyStimulus(key_bit(4'h7), 3);
    checkOutput("held_through_reset_pulse", total_pulses - base, 1);
    checkOutput("held_through_reset_code", key_code, 4'h7);
    applyStimulus(16'h0000, 3);

    applyReset(0);
    tap(4'h0); tap(4'h1); tap(4'h2);
    checkOutput("x_012", x, 12'h012);
    tap(4'hA);
    checkOutput("hex_code", key_code, 4'hA);
`ifdef KYPD_HEX_ENTRY_EN
    checkOutput("hex_x", x, 12'h12A);
`else
    checkOutput("hex_x", x, 12'h012);
`endif

    for (int t = 0; t < 40; t++) begin
      int sel;
      logic [15:0] k;
      sel = $urandom_range(0, 9);
      if (sel < 6) k = 16'h0001 << $urandom_range(0, 15);
      else if (sel < 8) k = 16'h0000;
      else k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      applyStimulus(k, $urandom_range(1, 5));
    end
    applyStimulus(16'h0000, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
